// File: rtl/irq_ctrl_if.sv
// Bus between the CPU side and the interrupt controller: interrupt lines,
// request/acknowledge handshake and the small configuration register port.
interface irq_ctrl_if #(
    parameter int NUM_IRQ = 16
);
    logic [NUM_IRQ-1:0] irq_in;
    logic               irq_req;
    logic [3:0]         irq_vec;
    logic               irq_ack;
    logic               irq_eoi;
    logic               cfg_wen;
    logic [1:0]         cfg_addr;
    logic [15:0]        cfg_wdata;
    logic [15:0]        cfg_rdata;

    // master: the CPU / system side that raises lines and services requests
    modport master (
        output irq_in, irq_ack, irq_eoi, cfg_wen, cfg_addr, cfg_wdata,
        input  irq_req, irq_vec, cfg_rdata
    );

    // slave: the interrupt controller itself
    modport slave (
        input  irq_in, irq_ack, irq_eoi, cfg_wen, cfg_addr, cfg_wdata,
        output irq_req, irq_vec, cfg_rdata
    );
endinterface

// File: rtl/irq_ctrl.sv
// Rising-edge interrupt controller: latches edges into PENDING, arbitrates
// unmasked sources by fixed priority (index 0 highest) and runs one at a time.
module irq_ctrl #(
    parameter int NUM_IRQ = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    irq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;

    state_t             state;
    logic               irq_req_q;
    logic [3:0]         irq_vec_q;
    logic [3:0]         in_service_vec;

    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] wr_clr;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [3:0]         first_idx;
    logic               do_ack;

    assign rise   = bus.irq_in & ~irq_prev;
    assign active = pending & mask;
    assign do_ack = (state == REQ) && bus.irq_ack;
    assign wr_clr = (bus.cfg_wen && bus.cfg_addr == ADDR_PENDING)
                  ? bus.cfg_wdata[NUM_IRQ-1:0] : '0;

    // Lowest set index wins: scan downwards so the last hit is the smallest.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) first_idx = 4'(i);
        end
    end

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_clr[i] = do_ack && (irq_vec_q == 4'(i));
        end
    end

    // A same-cycle edge is OR-ed in after the clears, so it always wins.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev <= '0;
            pending  <= '0;
            mask     <= '0;
        end else begin
            irq_prev <= bus.irq_in;
            pending  <= (pending & ~(wr_clr | ack_clr)) | rise;
            if (bus.cfg_wen && bus.cfg_addr == ADDR_MASK) begin
                mask <= bus.cfg_wdata[NUM_IRQ-1:0];
            end
        end
    end

    // irq_vec is captured on entry to REQ and frozen until the ack, so later
    // masking or clearing of the source cannot retarget an outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            irq_req_q      <= 1'b0;
            irq_vec_q      <= '0;
            in_service_vec <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|active) begin
                        state     <= REQ;
                        irq_req_q <= 1'b1;
                        irq_vec_q <= first_idx;
                    end
                end
                REQ: begin
                    if (bus.irq_ack) begin
                        state          <= SERVICE;
                        irq_req_q      <= 1'b0;
                        in_service_vec <= irq_vec_q;
                    end
                end
                SERVICE: begin
                    if (bus.irq_eoi) state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    irq_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq_req = irq_req_q;
    assign bus.irq_vec = irq_vec_q;

    always_comb begin
        logic [15:0] mask_ext;
        logic [15:0] pend_ext;
        mask_ext                = '0;
        pend_ext                = '0;
        mask_ext[NUM_IRQ-1:0]   = mask;
        pend_ext[NUM_IRQ-1:0]   = pending;
        case (bus.cfg_addr)
            ADDR_MASK:    bus.cfg_rdata = mask_ext;
            ADDR_PENDING: bus.cfg_rdata = pend_ext;
            ADDR_STATUS:  bus.cfg_rdata = {10'b0, state, in_service_vec};
            default:      bus.cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed and randomized bench for irq_ctrl against a cycle-level reference
// model of pending/mask bookkeeping and the request/service protocol.
module tb_irq_ctrl;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    irq_ctrl_if #(.NUM_IRQ(N)) bus ();
    irq_ctrl #(.NUM_IRQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: phase 0 idle, 1 requesting, 2 in service
    logic [15:0] m_pend, m_mask, m_prev;
    int          m_phase, m_vec, m_isv;
    logic [15:0] cur_in;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_mask;
            2'd1:    return m_pend;
            2'd2:    return {10'b0, 2'(m_phase), 4'(m_isv)};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_prev = '0;
        m_phase = 0; m_vec = 0; m_isv = 0;
    endtask

    // Apply one rising edge worth of rules to the model using the driven inputs.
    task automatic model_edge();
        logic [15:0] in_v, clr, n_pend, act;
        int k;
        in_v = 16'(bus.irq_in);
        clr  = '0;
        if (bus.cfg_wen && bus.cfg_addr == 2'd1) clr = clr | bus.cfg_wdata;
        if (m_phase == 1 && bus.irq_ack) clr = clr | (16'd1 << m_vec);
        n_pend = (m_pend & ~clr) | (in_v & ~m_prev);
        act = m_pend & m_mask;
        case (m_phase)
            0: if (act != 0) begin
                k = 0;
                while (!act[k]) k++;
                m_vec   = k;
                m_phase = 1;
            end
            1: if (bus.irq_ack) begin
                m_isv   = m_vec;
                m_phase = 2;
            end
            default: if (bus.irq_eoi) m_phase = 0;
        endcase
        if (bus.cfg_wen && bus.cfg_addr == 2'd0) m_mask = bus.cfg_wdata;
        m_pend = n_pend;
        m_prev = in_v;
    endtask

    task automatic step(input logic [15:0] in_v, input bit ack, input bit eoi, input bit wen,
                        input logic [1:0] addr, input logic [15:0] wd, input string tag);
        bus.irq_in    = in_v[N-1:0];
        bus.irq_ack   = ack;
        bus.irq_eoi   = eoi;
        bus.cfg_wen   = wen;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = wd;
        cur_in        = in_v;
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".req"},   16'(bus.irq_req), 16'(m_phase == 1));
        check({tag, ".vec"},   16'(bus.irq_vec), 16'(m_vec));
        check({tag, ".rdata"}, bus.cfg_rdata,    m_read(addr));
    endtask

    task automatic cyc(input logic [15:0] in_v, input string tag);
        step(in_v, 1'b0, 1'b0, 1'b0, 2'd1, 16'h0, tag);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [15:0] wd, input string tag);
        step(cur_in, 1'b0, 1'b0, 1'b1, addr, wd, tag);
    endtask

    task automatic ack(input string tag);
        step(cur_in, 1'b1, 1'b0, 1'b0, 2'd2, 16'h0, tag);
    endtask

    task automatic eoi(input string tag);
        step(cur_in, 1'b0, 1'b1, 1'b0, 2'd2, 16'h0, tag);
    endtask

    initial begin
        bus.irq_in = '0; bus.irq_ack = 0; bus.irq_eoi = 0;
        bus.cfg_wen = 0; bus.cfg_addr = 2'd0; bus.cfg_wdata = '0;
        cur_in = '0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check("rst.req", 16'(bus.irq_req), 16'h0);
        check("rst.vec", 16'(bus.irq_vec), 16'h0);
        for (int a = 0; a < 4; a++) begin
            bus.cfg_addr = 2'(a);
            #1;
            check($sformatf("rst.reg%0d", a), bus.cfg_rdata, 16'h0);
        end
        @(negedge clk) rst_n = 1'b1;

        // single unmasked source: one edge to pending, one more to request
        wr(2'd0, 16'h0004, "m4");
        cyc(16'h0004, "p2a");
        check("p2.pend", bus.cfg_rdata, 16'h0004);
        check("p2.noreq", 16'(bus.irq_req), 16'h0);
        cyc(16'h0000, "p2b");
        check("p2.req", 16'(bus.irq_req), 16'h1);
        check("p2.vec", 16'(bus.irq_vec), 16'h2);
        ack("p2ack");
        check("p2.status", bus.cfg_rdata, 16'h0022);
        eoi("p2eoi");

        // two simultaneous sources: priority then one IDLE cycle between
        wr(2'd0, 16'hFFFF, "mall");
        cyc(16'h0028, "p53a");
        cyc(16'h0000, "p53b");
        check("p53.vec3", 16'(bus.irq_vec), 16'h3);
        ack("p53ack3");
        eoi("p53eoi3");
        check("p53.idle", 16'(bus.irq_req), 16'h0);
        cyc(16'h0000, "p53c");
        check("p53.req5", 16'(bus.irq_req), 16'h1);
        check("p53.vec5", 16'(bus.irq_vec), 16'h5);
        ack("p53ack5");
        eoi("p53eoi5");

        // masked source stays pending until unmasked
        wr(2'd0, 16'h0000, "m0");
        cyc(16'h0080, "p7a");
        cyc(16'h0000, "p7b");
        cyc(16'h0000, "p7c");
        check("p7.pend", bus.cfg_rdata, 16'h0080);
        check("p7.noreq", 16'(bus.irq_req), 16'h0);
        wr(2'd0, 16'h0080, "m80");
        cyc(16'h0000, "p7d");
        check("p7.req", 16'(bus.irq_req), 16'h1);
        check("p7.vec", 16'(bus.irq_vec), 16'h7);
        ack("p7ack");
        eoi("p7eoi");

        // request holds its vector while software clears and masks the source
        wr(2'd0, 16'h0010, "m10");
        cyc(16'h0010, "p4a");
        cyc(16'h0000, "p4b");
        wr(2'd1, 16'h0010, "p4clr");
        wr(2'd0, 16'h0000, "p4mask");
        cyc(16'h0000, "p4c");
        check("p4.req", 16'(bus.irq_req), 16'h1);
        check("p4.vec", 16'(bus.irq_vec), 16'h4);
        ack("p4ack");
        check("p4.status", bus.cfg_rdata, 16'h0024);
        eoi("p4eoi");

        // same-cycle edge beats write-1-to-clear
        step(16'h0001, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0001, "w1c_race");
        check("race.pend", bus.cfg_rdata, 16'h0001);
        step(16'h0000, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0001, "w1c_clr");

        // reset while in service aborts immediately without a clock
        wr(2'd0, 16'h0001, "m1");
        cyc(16'h0001, "ab0");
        cyc(16'h0000, "ab1");
        ack("aback");
        check("ab.svc", bus.cfg_rdata, 16'h0020);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("ab.req", 16'(bus.irq_req), 16'h0);
        check("ab.status", bus.cfg_rdata, 16'h0000);
        bus.cfg_addr = 2'd0;
        #1;
        check("ab.mask", bus.cfg_rdata, 16'h0000);

        // a line held high through reset release counts as an edge
        bus.irq_in = 16'h0100;
        cur_in = 16'h0100;
        @(negedge clk) rst_n = 1'b1;
        cyc(16'h0100, "hold");
        check("hold.pend", bus.cfg_rdata, 16'h0100);

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            logic [15:0] nin;
            nin = cur_in;
            if ($urandom_range(0, 1) == 0) nin = nin ^ (16'd1 << $urandom_range(0, 15));
            step(nin, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)),
                 16'($urandom), $sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_IRQ, default 16, meaning the number of interrupt sources (1 to 16).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port irq_in, input, NUM_IRQ bits: level interrupt lines synchronous to clk (memory-mapped device flags OR PS/2 ready).
REQ-005 The module SHALL have port irq_req, output, 1 bit: interrupt request to the CPU.
REQ-006 The module SHALL have port irq_vec, output, 4 bits: index of the requested source.
REQ-007 The module SHALL have port irq_ack, input, 1 bit: single-cycle CPU acknowledge.
REQ-008 The module SHALL have port irq_eoi, input, 1 bit: single-cycle CPU end-of-interrupt.
REQ-009 The module SHALL have port cfg_wen, input, 1 bit: configuration write strobe.
REQ-010 The module SHALL have port cfg_addr, input, 2 bits: register select (0 MASK, 1 PENDING, 2 STATUS, 3 reserved).
REQ-011 The module SHALL have port cfg_wdata, input, 16 bits: write data.
REQ-012 The module SHALL have port cfg_rdata, output, 16 bits: combinational read data for cfg_addr.

Function
REQ-013 Edge detect: a registered copy irq_prev SHALL be kept; pending[i] SHALL set on any edge where irq_in[i]=1 and irq_prev[i]=0, independent of mask.
REQ-014 MASK (addr 0) SHALL be read/write; bit=1 enables the source; bits at or above NUM_IRQ SHALL read 0 and ignore writes.
REQ-015 PENDING (addr 1) SHALL be write-1-to-clear; a new edge on the same bit in the same cycle SHALL win (bit stays set).
REQ-016 STATUS (addr 2) SHALL read {10'b0, state[1:0], in_service_vec[3:0]}; writes to addr 2 or 3 SHALL be ignored; addr 3 SHALL read 0.
REQ-017 The state machine SHALL have states IDLE (0), REQ (1), SERVICE (2).
REQ-018 IDLE: if (pending & mask) is nonzero, the next state SHALL be REQ, with irq_vec latched to its lowest set index (index 0 highest priority).
REQ-019 REQ: irq_req SHALL be 1 and irq_vec SHALL hold stable until irq_ack, even if the source is later masked or cleared by software.
REQ-020 REQ with irq_ack=1: the next state SHALL be SERVICE, pending[irq_vec] SHALL clear (unless a same-cycle edge re-sets it), and in_service_vec SHALL be set to irq_vec.
REQ-021 SERVICE: irq_req SHALL be 0 (no nesting); on irq_eoi=1 the next state SHALL be IDLE.
REQ-022 irq_ack outside REQ and irq_eoi outside SERVICE SHALL be ignored; if both are asserted together, only the one valid for the current state SHALL act.
REQ-023 Latency: if irq_in[i] rises before edge k, pending[i]=1 after edge k, and irq_req=1 after edge k+1, provided the FSM is IDLE and the source is unmasked.
REQ-024 After an EOI, IDLE SHALL re-arbitrate the next cycle, so back-to-back pending sources SHALL be served with one IDLE cycle between them.
REQ-025 irq_req SHALL be a registered output equal to (state==REQ).

Reset
REQ-026 While rst_n=0, the module SHALL hold state=IDLE, irq_req=0, irq_vec=0, in_service_vec=0, pending=0, mask=0, and irq_prev=0.
REQ-027 Reset SHALL take effect immediately on rst_n falling, aborting REQ or SERVICE with no ack required.
REQ-028 If irq_in is held high through reset release, it SHALL register as an edge on the first clock after release.

Verification
REQ-029 MASK=0x0004, pulse irq_in[2] -> pending=0x0004 after 1 edge, irq_req=1 with irq_vec=2 after the next edge.
REQ-030 MASK=0xFFFF, irq_in[5] and irq_in[3] rise together -> irq_vec=3; ack, then eoi -> one IDLE cycle, then irq_vec=5.
REQ-031 MASK=0, pulse irq_in[7] -> pending bit 7 set, irq_req stays 0; write MASK=0x0080 -> irq_req=1 after 1 cycle with irq_vec=7.
REQ-032 While in REQ for vector 4, write PENDING=0x0010 and MASK=0 -> irq_vec stays 4 and irq_req stays 1 until ack.
REQ-033 Write PENDING=0x0001 in the same cycle irq_in[0] rises -> pending[0]=1.
REQ-034 Drop rst_n mid-SERVICE -> STATUS=0 and irq_req=0 immediately, with no clock needed.
